// File: rtl/counter_pkg.sv
// Shared types and helpers for the bounded up/down counter.
// Provides direction/mode enums and a range clamp used on load.
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Clamp an unsigned value into [lo, hi].
    function automatic logic [31:0] cnt_clamp(
        input logic [31:0] value,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/updown_counter_next_calc.sv
// counter_next_calc: combinational next-value computation for one count step.
// Ports: count/dir/step in; next_count and overflow (range crossed) out.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int STEP_WIDTH  = 4,
    parameter int COUNT_FROM  = 0,
    parameter int COUNT_TO    = (2**COUNT_WIDTH)-1,
    parameter int SATURATE    = 0
) (
    input  logic [COUNT_WIDTH-1:0] count,
    input  cnt_dir_e               dir,
    input  logic [STEP_WIDTH-1:0]  step,
    output logic [COUNT_WIDTH-1:0] next_count,
    output logic                   overflow
);

    // Two guard bits above the wider operand keep sums and
    // differences exact; the top bit doubles as a sign for down steps.
    localparam int AW = ((COUNT_WIDTH > STEP_WIDTH) ?
                         COUNT_WIDTH : STEP_WIDTH) + 2;

    localparam logic [AW-1:0] LO = AW'(COUNT_FROM);
    localparam logic [AW-1:0] HI = AW'(COUNT_TO);
    localparam logic [AW-1:0] R  = AW'(COUNT_TO - COUNT_FROM + 1);

    localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    logic [AW-1:0] cnt_x;
    logic [AW-1:0] stp_x;
    logic [AW-1:0] up_sum;
    logic [AW-1:0] dn_dif;
    logic [AW-1:0] nxt_x;

    assign cnt_x  = AW'(count);
    assign stp_x  = AW'(step);
    assign up_sum = cnt_x + stp_x;
    assign dn_dif = cnt_x - stp_x;

    always_comb begin
        nxt_x    = cnt_x;
        overflow = 1'b0;
        if (dir == CNT_UP) begin
            if (up_sum <= HI) begin
                nxt_x = up_sum;
            end else begin
                overflow = 1'b1;
                nxt_x    = (MODE == CNT_SAT) ? HI : (up_sum - R);
            end
        end else begin
            if ($signed(dn_dif) >= $signed(LO)) begin
                nxt_x = dn_dif;
            end else begin
                overflow = 1'b1;
                nxt_x    = (MODE == CNT_SAT) ? LO : (dn_dif + R);
            end
        end
    end

    assign next_count = COUNT_WIDTH'(nxt_x);

endmodule

// File: rtl/updown_counter.sv
// updown_counter: bounded up/down counter with wrap/saturate, clear, load
// and a registered wrap event pulse. Ports: clk, rst (async high), clr,
// load, load_value, en, dir, step -> count, at_min, at_max, wrap.
// Define UPDOWN_COUNTER_CASCADE_EN to add carry_in/carry_out for chaining.
module updown_counter
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int STEP_WIDTH  = 4,
    parameter int COUNT_FROM  = 0,
    parameter int COUNT_TO    = (2**COUNT_WIDTH)-1,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   en,
    input  logic                   dir,
    input  logic [STEP_WIDTH-1:0]  step,
`ifdef UPDOWN_COUNTER_CASCADE_EN
    input  logic                   carry_in,
    output logic                   carry_out,
`endif
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   at_min,
    output logic                   at_max,
    output logic                   wrap
);

    localparam int AW = ((COUNT_WIDTH > STEP_WIDTH) ?
                         COUNT_WIDTH : STEP_WIDTH) + 2;
    localparam logic [AW-1:0] R = AW'(COUNT_TO - COUNT_FROM + 1);

    localparam logic [COUNT_WIDTH-1:0] LO = COUNT_WIDTH'(COUNT_FROM);
    localparam logic [COUNT_WIDTH-1:0] HI = COUNT_WIDTH'(COUNT_TO);

    logic                   eff_en;
    logic [COUNT_WIDTH-1:0] next_count;
    logic                   overflow;
    logic [COUNT_WIDTH-1:0] load_clamped;

    assign at_min = (count == LO);
    assign at_max = (count == HI);

`ifdef UPDOWN_COUNTER_CASCADE_EN
    assign eff_en = en & carry_in;
    // Combinational so the next stage advances in the same cycle.
    assign carry_out = eff_en & (step != '0) & (dir ? at_max : at_min);
`else
    assign eff_en = en;
`endif

    assign load_clamped = COUNT_WIDTH'(cnt_clamp(32'(load_value),
                                                 32'(COUNT_FROM),
                                                 32'(COUNT_TO)));

    counter_next_calc #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .STEP_WIDTH  (STEP_WIDTH),
        .COUNT_FROM  (COUNT_FROM),
        .COUNT_TO    (COUNT_TO),
        .SATURATE    (SATURATE)
    ) u_next (
        .count      (count),
        .dir        (cnt_dir_e'(dir)),
        .step       (step),
        .next_count (next_count),
        .overflow   (overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= LO;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= LO;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (eff_en) begin
            count <= next_count;
            wrap  <= overflow;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // A step larger than the range would skip past a full period.
    always @(posedge clk) begin
        if (!rst && !clr && !load && eff_en) begin
            assert (AW'(step) <= R)
            else $error("updown_counter: step %0d exceeds range %0d",
                        step, R);
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed vectors, hand sequences,
// randomized run against a reference model, and cascade chaining.
module tb_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Shared stimulus for u0 (0..255 wrap), u1 (10..20 wrap), u2 (10..20 sat)
    logic       a_clr, a_load, a_en, a_dir;
    logic [7:0] a_lv;
    logic [3:0] a_st;

    logic [7:0] c0, c1, c2;
    logic       mn0, mx0, w0, mn1, mx1, w1, mn2, mx2, w2;

    // Stimulus for u3 (degenerate range 5..5)
    logic       d_clr, d_load, d_en, d_dir;
    logic [3:0] d_lv, d_st, c3;
    logic       mn3, mx3, w3;

`ifdef UPDOWN_COUNTER_CASCADE_EN
    logic co0, co1, co2, co3;
    logic k_load, k_en;
    logic [3:0] k_lv_lo, k_lv_hi, k_lo, k_hi;
    logic k_co_lo, k_co_hi, k_mn_lo, k_mx_lo, k_w_lo;
    logic k_mn_hi, k_mx_hi, k_w_hi;
`endif

    updown_counter #(.COUNT_WIDTH(8), .STEP_WIDTH(4)) u0 (
        .clk(clk), .rst(rst), .clr(a_clr), .load(a_load),
        .load_value(a_lv), .en(a_en), .dir(a_dir), .step(a_st),
`ifdef UPDOWN_COUNTER_CASCADE_EN
        .carry_in(1'b1), .carry_out(co0),
`endif
        .count(c0), .at_min(mn0), .at_max(mx0), .wrap(w0));

    updown_counter #(.COUNT_WIDTH(8), .STEP_WIDTH(4),
                     .COUNT_FROM(10), .COUNT_TO(20), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .clr(a_clr), .load(a_load),
        .load_value(a_lv), .en(a_en), .dir(a_dir), .step(a_st),
`ifdef UPDOWN_COUNTER_CASCADE_EN
        .carry_in(1'b1), .carry_out(co1),
`endif
        .count(c1), .at_min(mn1), .at_max(mx1), .wrap(w1));

    updown_counter #(.COUNT_WIDTH(8), .STEP_WIDTH(4),
                     .COUNT_FROM(10), .COUNT_TO(20), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst), .clr(a_clr), .load(a_load),
        .load_value(a_lv), .en(a_en), .dir(a_dir), .step(a_st),
`ifdef UPDOWN_COUNTER_CASCADE_EN
        .carry_in(1'b1), .carry_out(co2),
`endif
        .count(c2), .at_min(mn2), .at_max(mx2), .wrap(w2));

    updown_counter #(.COUNT_WIDTH(4), .STEP_WIDTH(4),
                     .COUNT_FROM(5), .COUNT_TO(5)) u3 (
        .clk(clk), .rst(rst), .clr(d_clr), .load(d_load),
        .load_value(d_lv), .en(d_en), .dir(d_dir), .step(d_st),
`ifdef UPDOWN_COUNTER_CASCADE_EN
        .carry_in(1'b1), .carry_out(co3),
`endif
        .count(c3), .at_min(mn3), .at_max(mx3), .wrap(w3));

`ifdef UPDOWN_COUNTER_CASCADE_EN
    updown_counter #(.COUNT_WIDTH(4), .STEP_WIDTH(4)) k_lo_s (
        .clk(clk), .rst(rst), .clr(1'b0), .load(k_load),
        .load_value(k_lv_lo), .en(k_en), .dir(1'b1), .step(4'd1),
        .carry_in(1'b1), .carry_out(k_co_lo),
        .count(k_lo), .at_min(k_mn_lo), .at_max(k_mx_lo), .wrap(k_w_lo));

    updown_counter #(.COUNT_WIDTH(4), .STEP_WIDTH(4)) k_hi_s (
        .clk(clk), .rst(rst), .clr(1'b0), .load(k_load),
        .load_value(k_lv_hi), .en(k_en), .dir(1'b1), .step(4'd1),
        .carry_in(k_co_lo), .carry_out(k_co_hi),
        .count(k_hi), .at_min(k_mn_hi), .at_max(k_mx_hi), .wrap(k_w_hi));
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the counter's rules applied with plain integer arithmetic.
    function automatic int ref_next(
        input int c, input int lo, input int hi, input bit sat,
        input bit clr, input bit ld, input int lv,
        input bit en, input bit up, input int st, output bit w);
        int r;
        int t;
        r = hi - lo + 1;
        w = 1'b0;
        if (clr) return lo;
        if (ld) return (lv < lo) ? lo : ((lv > hi) ? hi : lv);
        if (!en) return c;
        t = up ? c + st : c - st;
        if (t > hi) begin
            w = 1'b1;
            return sat ? hi : t - r;
        end
        if (t < lo) begin
            w = 1'b1;
            return sat ? lo : t + r;
        end
        return t;
    endfunction

    typedef struct {
        bit clr; bit ld; int lv; bit en; bit up; int st;
        int e1; bit ew1; int e2; bit ew2;
    } vec_t;

    vec_t vt[13];

    initial begin
        int m0, m1, m2;
        bit x0, x1, x2;

        vt[0]  = '{0, 1,  18, 0, 0,  0, 18, 0, 18, 0};
        vt[1]  = '{0, 0,   0, 1, 1,  5, 12, 1, 20, 1};
        vt[2]  = '{0, 0,   0, 1, 1,  5, 17, 0, 20, 1};
        vt[3]  = '{0, 1,  12, 0, 0,  0, 12, 0, 12, 0};
        vt[4]  = '{0, 0,   0, 1, 0,  4, 19, 1, 10, 1};
        vt[5]  = '{0, 0,   0, 1, 0,  4, 15, 0, 10, 1};
        vt[6]  = '{0, 0,   0, 0, 0,  4, 15, 0, 10, 0};
        vt[7]  = '{1, 1, 200, 1, 1,  3, 10, 0, 10, 0};
        vt[8]  = '{0, 1, 200, 0, 1,  3, 20, 0, 20, 0};
        vt[9]  = '{0, 0,   0, 1, 1,  0, 20, 0, 20, 0};
        vt[10] = '{0, 1,   3, 0, 1,  0, 10, 0, 10, 0};
        vt[11] = '{0, 0,   0, 1, 1, 11, 10, 1, 20, 1};
        vt[12] = '{0, 0,   0, 1, 0, 11, 10, 1, 10, 1};

        rst = 1'b1;
        a_clr = 0; a_load = 0; a_en = 0; a_dir = 0; a_lv = 0; a_st = 0;
        d_clr = 0; d_load = 0; d_en = 0; d_dir = 0; d_lv = 0; d_st = 0;
`ifdef UPDOWN_COUNTER_CASCADE_EN
        k_load = 0; k_en = 0; k_lv_lo = 0; k_lv_hi = 0;
`endif
        #12;
        check("rst_c0", int'(c0), 0);
        check("rst_w0", int'(w0), 0);
        check("rst_min0", int'(mn0), 1);
        check("rst_max0", int'(mx0), 0);
        check("rst_c1", int'(c1), 10);
        check("rst_max3", int'(mx3), 1);
        check("rst_min3", int'(mn3), 1);
        @(negedge clk);
        rst = 1'b0;

        // Count to 37, then reset asynchronously between edges.
        a_load = 1; a_lv = 8'd30;
        tick();
        a_load = 0; a_en = 1; a_dir = 1; a_st = 4'd7;
        tick();
        a_en = 0;
        check("cnt37", int'(c0), 37);
        check("u1_wrap_pre", int'(w1), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_c0", int'(c0), 0);
        check("async_w0", int'(w0), 0);
        check("async_min0", int'(mn0), 1);
        check("async_c1", int'(c1), 10);
        check("async_w1", int'(w1), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            a_clr = vt[i].clr; a_load = vt[i].ld; a_lv = 8'(vt[i].lv);
            a_en = vt[i].en; a_dir = vt[i].up; a_st = 4'(vt[i].st);
            tick();
            check($sformatf("vec%0d_c1", i), int'(c1), vt[i].e1);
            check($sformatf("vec%0d_w1", i), int'(w1), int'(vt[i].ew1));
            check($sformatf("vec%0d_c2", i), int'(c2), vt[i].e2);
            check($sformatf("vec%0d_w2", i), int'(w2), int'(vt[i].ew2));
            check($sformatf("vec%0d_max1", i), int'(mx1),
                  (vt[i].e1 == 20) ? 1 : 0);
            check($sformatf("vec%0d_min1", i), int'(mn1),
                  (vt[i].e1 == 10) ? 1 : 0);
        end
        a_clr = 0; a_load = 0; a_en = 0;

        // Degenerate single-value range.
        d_en = 1; d_dir = 1; d_st = 4'd1;
        tick();
        check("deg_up_c", int'(c3), 5);
        check("deg_up_w", int'(w3), 1);
        d_dir = 0;
        tick();
        check("deg_dn_c", int'(c3), 5);
        check("deg_dn_w", int'(w3), 1);
        d_st = 4'd0;
        tick();
        check("deg_z_w", int'(w3), 0);
        d_en = 0;

        // Randomized run against the reference model.
        a_clr = 1;
        tick();
        a_clr = 0;
        m0 = 0; m1 = 10; m2 = 10;
        for (int i = 0; i < 400; i++) begin
            a_clr  = ($urandom_range(0, 15) == 0);
            a_load = ($urandom_range(0, 7) == 0);
            a_en   = ($urandom_range(0, 3) != 0);
            a_dir  = $urandom_range(0, 1) != 0;
            a_lv   = 8'($urandom_range(0, 255));
            a_st   = 4'($urandom_range(0, 11));
            m0 = ref_next(m0, 0, 255, 0, a_clr, a_load, int'(a_lv),
                          a_en, a_dir, int'(a_st), x0);
            m1 = ref_next(m1, 10, 20, 0, a_clr, a_load, int'(a_lv),
                          a_en, a_dir, int'(a_st), x1);
            m2 = ref_next(m2, 10, 20, 1, a_clr, a_load, int'(a_lv),
                          a_en, a_dir, int'(a_st), x2);
            tick();
            check("rnd_c0", int'(c0), m0);
            check("rnd_w0", int'(w0), int'(x0));
            check("rnd_c1", int'(c1), m1);
            check("rnd_w1", int'(w1), int'(x1));
            check("rnd_c2", int'(c2), m2);
            check("rnd_w2", int'(w2), int'(x2));
            check("rnd_max2", int'(mx2), (m2 == 20) ? 1 : 0);
        end
        a_clr = 0; a_load = 0; a_en = 0;

`ifdef UPDOWN_COUNTER_CASCADE_EN
        k_load = 1; k_lv_lo = 4'hE; k_lv_hi = 4'h0;
        tick();
        k_load = 0;
        k_en = 1;
        #1;
        check("casc_0e", int'({k_hi, k_lo}), 8'h0E);
        check("casc_co_0e", int'(k_co_lo), 0);
        tick();
        check("casc_0f", int'({k_hi, k_lo}), 8'h0F);
        check("casc_co_0f", int'(k_co_lo), 1);
        tick();
        check("casc_10", int'({k_hi, k_lo}), 8'h10);
        check("casc_co_10", int'(k_co_lo), 0);
        k_en = 0;
        #1;
        check("casc_co_idle", int'(k_co_lo), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Next-generation parametrised counter for the common-blocks library. It counts up or down by a runtime step inside a bounded range [COUNT_FROM, COUNT_TO], with wrap or saturate mode, synchronous clear and load, and a registered overflow/underflow event pulse. It is used as a timer, index generator or rate divider wherever a plain free-running counter is insufficient.

Parameters:
COUNT_WIDTH, 8, count bit width
STEP_WIDTH, 4, width of runtime step input
COUNT_FROM, 0, lower bound; reset value
COUNT_TO, (2**COUNT_WIDTH)-1, upper bound; must satisfy COUNT_FROM <= COUNT_TO < 2**COUNT_WIDTH
SATURATE, 0, 0 = wrap modulo range, 1 = clip at bound

Ports:
clk  input  1  counter clock
rst  input  1  reset, asynchronous, active-high
clr  input  1  synchronous clear to COUNT_FROM
load  input  1  synchronous load of load_value
load_value  input  COUNT_WIDTH  value to load
en  input  1  count enable
dir  input  1  1 = up, 0 = down
step  input  STEP_WIDTH  increment/decrement magnitude
count  output  COUNT_WIDTH  current count (registered)
at_min  output  1  combinational, count == COUNT_FROM
at_max  output  1  combinational, count == COUNT_TO
wrap  output  1  registered one-cycle event pulse

Behaviour:
- Reset (async assert, sync release): count = COUNT_FROM, wrap = 0. at_min = 1. at_max = 1 only if COUNT_FROM == COUNT_TO.
- Per-cycle priority: clr > load > en. With none of the three active, count holds and wrap = 0.
- clr: count <= COUNT_FROM, wrap <= 0.
- load: count <= load_value, clamped to [COUNT_FROM, COUNT_TO]; wrap <= 0.
- en with step == 0: count holds, wrap <= 0.
- Arithmetic: compute in COUNT_WIDTH+2 bits, unsigned, so no intermediate overflow. R = COUNT_TO - COUNT_FROM + 1.
- step > R is illegal; a simulation assertion fires. RTL behaviour for an illegal step is unspecified.
- Up, count+step <= COUNT_TO: count <= count+step, wrap <= 0.
- Up, overshoot: wrap <= 1.
  - SATURATE=0: count <= count+step-R.
  - SATURATE=1: count <= COUNT_TO.
- Down, count-step >= COUNT_FROM (signed compare): count <= count-step, wrap <= 0.
- Down, undershoot: wrap <= 1.
  - SATURATE=0: count <= count-step+R.
  - SATURATE=1: count <= COUNT_FROM.
- SATURATE=1 sitting at a bound and stepping outward: count holds, wrap pulses every such cycle.
- Latency: count and wrap update 1 cycle after the sampled control inputs.
- Full range (COUNT_FROM=0, COUNT_TO=2**W-1) behaves as natural modulo 2**W in wrap mode.
- Degenerate range R=1: every non-zero step produces wrap=1 and count stays at the single value.

Optional Feature:
- Macro: UPDOWN_COUNTER_CASCADE_EN.
- When defined:
  - Adds input carry_in (1) and output carry_out (1).
  - Effective enable = en & carry_in.
  - carry_out = effective enable & (step != 0) & (dir ? at_max : at_min), combinational, so carry_out of one stage drives carry_in of the next stage in the same cycle.
- When undefined:
  - Neither port exists.
  - carry_in is internally treated as 1.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {CNT_DOWN=0, CNT_UP=1} cnt_dir_e.
  - typedef enum logic {CNT_WRAP=0, CNT_SAT=1} cnt_mode_e.
  - Function cnt_clamp(value, lo, hi).
- Sub-module counter_next_calc: purely combinational.
  - Inputs: count, dir, step.
  - Outputs: next_count, overflow.
  - Parametrised identically to the top.
- The top holds the registers, priority logic and assertion.

Test Plan:
- Reset mid-count: W=8 default; count to 37, assert rst asynchronously between edges -> count=0 immediately, wrap=0, at_min=1.
- Wrap up: COUNT_FROM=10, COUNT_TO=20, load 18, en, dir=1, step=5 -> next count=12, wrap=1 for exactly one cycle, then 17 with wrap=0.
- Wrap down: same range, count=12, dir=0, step=4 -> count=19, wrap=1.
- Saturate: SATURATE=1, COUNT_TO=20, count=18, step=5 up -> 20, wrap=1; hold en -> count 20, wrap=1 each cycle.
- Priority and clamp: clr, load (load_value=200, range 10..20) and en all high -> count=10. Next cycle only load=1 -> count=20. step=0 with en -> holds, wrap=0.
- Cascade (macro defined): two 4-bit stages chained, step=1 up -> 8-bit count 0x0F->0x10 in one cycle. carry_out of the low stage is high only when the low count is 0xF.
